act_out_axi_writer: RTL and testbench

- AXI4 write-side master for the activation (ACT) unit.
- Accepts the activation result stream, one pixel of Tout channels per beat, ordered channel-group-major, then row, then column.
- Writes the stream to HBM at DAT_OUT base/surface/line strides using fixed-length INCR bursts, and tracks write responses.
- Counterpart of the input-side reader; the ACT top instantiates it on the DAT_OUT path.

---
 rtl/act_pkg.sv | 22 ++
 rtl/act_addr_gen.sv | 82 ++++++++
 rtl/act_out_axi_writer.sv | 153 +++++++++++++++
 tb/tb_act_out_axi_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared AXI constants, FSM state type and helpers for the ACT DAT_OUT write master.
package act_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } act_state_t;

    // AXI size code: log2 of the bytes carried by one beat.
    function automatic logic [2:0] calc_awsize(input int data_w);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((data_w / 8) == (1 << i)) size = 3'(i);
        end
        return size;
    endfunction
endpackage

// File: rtl/act_addr_gen.sv
// Burst address walker: channel group -> row -> burst-in-row, built from running sums.
module act_addr_gen
    import act_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DIM_W       = 16,
    parameter int BURST_LEN   = 16,
    parameter int BURST_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              next,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] surface_stride,
    input  logic [ADDR_W-1:0] line_stride,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [DIM_W-1:0]  ch_groups,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam int BL_LOG = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_BYTES);

    logic [DIM_W-1:0]  wb, h, g;
    logic [DIM_W-1:0]  wb_last, h_last, g_last;
    logic [ADDR_W-1:0] surf_q, line_q, grp_base, row_base;
    logic              wb_end, h_end, g_end;

    assign wb_end = (wb == wb_last);
    assign h_end  = (h == h_last);
    assign g_end  = (g == g_last);
    assign last   = wb_end & h_end & g_end;

    // grp_base and row_base hold the start of the current surface and row so
    // each wrap is a single add rather than a multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb       <= '0;
            h        <= '0;
            g        <= '0;
            wb_last  <= '0;
            h_last   <= '0;
            g_last   <= '0;
            surf_q   <= '0;
            line_q   <= '0;
            grp_base <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (init) begin
            wb       <= '0;
            h        <= '0;
            g        <= '0;
            wb_last  <= (width >> BL_LOG) - 1'b1;
            h_last   <= height - 1'b1;
            g_last   <= ch_groups - 1'b1;
            surf_q   <= surface_stride;
            line_q   <= line_stride;
            grp_base <= base_addr;
            row_base <= base_addr;
            addr     <= base_addr;
        end else if (next) begin
            if (!wb_end) begin
                wb   <= wb + 1'b1;
                addr <= addr + BURST_STEP;
            end else if (!h_end) begin
                wb       <= '0;
                h        <= h + 1'b1;
                row_base <= row_base + line_q;
                addr     <= row_base + line_q;
            end else begin
                wb       <= '0;
                h        <= '0;
                g        <= g + 1'b1;
                grp_base <= grp_base + surf_q;
                row_base <= grp_base + surf_q;
                addr     <= grp_base + surf_q;
            end
        end
    end
endmodule

// File: rtl/act_out_axi_writer.sv
// AXI4 write master streaming ACT results to DAT_OUT with fixed-length INCR bursts.
module act_out_axi_writer
    import act_pkg::*;
#(
    parameter int AXI_DW    = 512,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int BURST_LEN = 16,
    parameter int DIM_W     = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [ADDR_W-1:0]   cfg_surface_stride,
    input  logic [ADDR_W-1:0]   cfg_line_stride,
    input  logic [DIM_W-1:0]    cfg_width,
    input  logic [DIM_W-1:0]    cfg_height,
    input  logic [DIM_W-1:0]    cfg_ch_groups,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [AXI_DW-1:0]   s_data,
    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [AXI_DW-1:0]   m_wdata,
    output logic [AXI_DW/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);
    localparam int OUT_W  = $clog2(MAX_OUTST + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    act_state_t       state, state_nxt;
    logic [OUT_W-1:0] outstanding, w_credit;
    logic [BEAT_W-1:0] beat;
    logic             aw_done, w_done, addr_last;
    logic             start_ok, dims_zero, aw_hs, w_hs, b_hs;
    logic             w_allowed, w_burst_end, last_w;
    logic             unused_bid;

    assign unused_bid = ^m_bid;
    assign start_ok   = start && (state == ST_IDLE);
    assign dims_zero  = (cfg_width == '0) || (cfg_height == '0) || (cfg_ch_groups == '0);

    // A transfer happens on a cycle where valid and ready are both high; a
    // master holds valid and payload stable until that cycle.
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = m_bvalid & m_bready;

    assign m_awid    = '0;
    assign m_awlen   = 8'(BURST_LEN - 1);
    assign m_awsize  = calc_awsize(AXI_DW);
    assign m_awburst = AXI_BURST_INCR;
    assign m_wstrb   = '1;
    assign m_awvalid = (state == ST_RUN) && !aw_done && (outstanding < OUT_W'(MAX_OUTST));

    // w_credit counts bursts whose AW is issued but whose W is not complete,
    // so data can never run ahead of its address.
    assign w_allowed   = (state == ST_RUN) && (w_credit != '0);
    assign m_wvalid    = s_valid & w_allowed;
    assign s_ready     = m_wready & w_allowed;
    assign m_wdata     = s_data;
    assign m_wlast     = (beat == BEAT_W'(BURST_LEN - 1));
    assign w_burst_end = w_hs & m_wlast;
    assign last_w      = w_burst_end && aw_done && (w_credit == OUT_W'(1));

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign m_bready = (state == ST_RUN) || (state == ST_DRAIN);

    act_addr_gen #(
        .ADDR_W     (ADDR_W),
        .DIM_W      (DIM_W),
        .BURST_LEN  (BURST_LEN),
        .BURST_BYTES(BURST_LEN * (AXI_DW / 8))
    ) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .init          (start_ok),
        .next          (aw_hs),
        .base_addr     (cfg_base_addr),
        .surface_stride(cfg_surface_stride),
        .line_stride   (cfg_line_stride),
        .width         (cfg_width),
        .height        (cfg_height),
        .ch_groups     (cfg_ch_groups),
        .addr          (m_awaddr),
        .last          (addr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            outstanding <= '0;
            w_credit    <= '0;
            beat        <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                outstanding <= '0;
                w_credit    <= '0;
                beat        <= '0;
                aw_done     <= 1'b0;
                w_done      <= 1'b0;
                err         <= 1'b0;
            end else begin
                case ({aw_hs, b_hs})
                    2'b10:   outstanding <= outstanding + 1'b1;
                    2'b01:   outstanding <= outstanding - 1'b1;
                    default: outstanding <= outstanding;
                endcase
                case ({aw_hs, w_burst_end})
                    2'b10:   w_credit <= w_credit + 1'b1;
                    2'b01:   w_credit <= w_credit - 1'b1;
                    default: w_credit <= w_credit;
                endcase
                if (w_hs) beat <= m_wlast ? '0 : beat + 1'b1;
                if (aw_hs && addr_last) aw_done <= 1'b1;
                if (last_w) w_done <= 1'b1;
                if (b_hs && (m_bresp != RESP_OKAY)) err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = dims_zero ? ST_DONE : ST_RUN;
            ST_RUN:   if (aw_done && w_done) state_nxt = ST_DRAIN;
            ST_DRAIN: if (outstanding == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_act_out_axi_writer.sv
// Randomized bench for act_out_axi_writer against a burst/beat-level model of DAT_OUT writes.
module tb_act_out_axi_writer;
    localparam int AXI_DW      = 512;
    localparam int ADDR_W      = 32;
    localparam int ID_W        = 4;
    localparam int BL          = 16;
    localparam int DIM_W       = 16;
    localparam int MAX_OUTST   = 4;
    localparam int BURST_BYTES = BL * AXI_DW / 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   cfg_base_addr = '0, cfg_surface_stride = '0, cfg_line_stride = '0;
    logic [DIM_W-1:0]    cfg_width = '0, cfg_height = '0, cfg_ch_groups = '0;
    logic                busy, done, err;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [AXI_DW-1:0]   s_data = '0;
    logic [ID_W-1:0]     m_awid;
    logic [ADDR_W-1:0]   m_awaddr;
    logic [7:0]          m_awlen;
    logic [2:0]          m_awsize;
    logic [1:0]          m_awburst;
    logic                m_awvalid;
    logic                m_awready = 1'b0;
    logic [AXI_DW-1:0]   m_wdata;
    logic [AXI_DW/8-1:0] m_wstrb;
    logic                m_wlast, m_wvalid;
    logic                m_wready = 1'b0;
    logic [ID_W-1:0]     m_bid = '0;
    logic [1:0]          m_bresp = 2'b00;
    logic                m_bvalid = 1'b0;
    logic                m_bready;

    always #5 clk = ~clk;

    act_out_axi_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_surface_stride(cfg_surface_stride),
        .cfg_line_stride(cfg_line_stride), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_ch_groups(cfg_ch_groups),
        .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [AXI_DW-1:0] stream_q[$];
    logic [ADDR_W-1:0] exp_q[$];
    int                b_due_q[$];
    int cyc, aw_cnt, w_beats, w_bursts, b_cnt, done_cnt, beat_idx;
    int aw_block, aw_rate, w_rate, sv_rate, b_delay, err_idx;
    bit start_req, s_take, b_take, aw_hold;
    logic [ADDR_W-1:0] aw_hold_addr;

    task automatic check(input string tag, input logic [AXI_DW-1:0] got, input logic [AXI_DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, commit at the rising edge.
    task automatic step();
        logic [ADDR_W-1:0] exp_addr;
        @(negedge clk);
        start = start_req;
        start_req = 1'b0;
        if (s_take) begin s_valid = 1'b0; beat_idx++; s_take = 1'b0; end
        if (b_take) begin m_bvalid = 1'b0; b_take = 1'b0; end
        if (!s_valid && beat_idx < stream_q.size() && $urandom_range(99) < sv_rate) begin
            s_valid = 1'b1;
            s_data  = stream_q[beat_idx];
        end
        m_awready = (cyc >= aw_block) && ($urandom_range(99) < aw_rate);
        m_wready  = ($urandom_range(99) < w_rate);
        if (!m_bvalid && b_due_q.size() > 0) begin
            if (cyc >= b_due_q[0]) begin
                void'(b_due_q.pop_front());
                m_bvalid = 1'b1;
                m_bresp  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
                m_bid    = ID_W'($urandom);
            end
        end
        #1;
        if (aw_hold) begin
            check("aw_hold_valid", m_awvalid, 1'b1);
            check("aw_hold_addr", m_awaddr, aw_hold_addr);
        end
        aw_hold = m_awvalid && !m_awready;
        aw_hold_addr = m_awaddr;
        if (m_wvalid && m_wready) begin
            check("w_after_aw", w_bursts < aw_cnt, 1'b1);
            check("w_s_ready", s_ready, 1'b1);
            if (w_beats < stream_q.size()) check("wdata", m_wdata, stream_q[w_beats]);
            else check("w_extra", 1'b1, 1'b0);
            check("wlast", m_wlast, (w_beats % BL) == BL - 1);
            w_beats++;
            if (m_wlast) begin
                w_bursts++;
                b_due_q.push_back(cyc + b_delay);
            end
        end
        if (m_awvalid && m_awready) begin
            if (exp_q.size() == 0) check("aw_extra", 1'b1, 1'b0);
            else begin
                exp_addr = exp_q.pop_front();
                check("awaddr", m_awaddr, exp_addr);
            end
            check("outst_lim", (aw_cnt - b_cnt) < MAX_OUTST, 1'b1);
            check("awlen", m_awlen, BL - 1);
            check("awsize", m_awsize, 3'd6);
            aw_cnt++;
        end
        if (m_bvalid && m_bready) begin b_cnt++; b_take = 1'b1; end
        if (s_valid && s_ready) s_take = 1'b1;
        if (done) done_cnt++;
        cyc++;
    endtask

    task automatic run_test(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] surf,
                            input logic [ADDR_W-1:0] line, input int w, input int h, input int g,
                            input int awb, input int awr, input int wr, input int svr,
                            input int bd, input int ei, input int inject, input int abort_at);
        int nb, n_bursts;
        stream_q.delete(); exp_q.delete(); b_due_q.delete();
        cyc = 0; aw_cnt = 0; w_beats = 0; w_bursts = 0; b_cnt = 0; done_cnt = 0; beat_idx = 0;
        s_take = 1'b0; b_take = 1'b0; aw_hold = 1'b0;
        s_valid = 1'b0; m_bvalid = 1'b0;
        aw_block = awb; aw_rate = awr; w_rate = wr; sv_rate = svr; b_delay = bd; err_idx = ei;
        nb = w * h * g;
        for (int i = 0; i < nb; i++) stream_q.push_back({16{$urandom}});
        for (int gi = 0; gi < g; gi++)
            for (int hi = 0; hi < h; hi++)
                for (int wi = 0; wi < w / BL; wi++)
                    exp_q.push_back(base + ADDR_W'(gi) * surf + ADDR_W'(hi) * line
                                    + ADDR_W'(wi * BURST_BYTES));
        n_bursts = exp_q.size();
        cfg_base_addr = base; cfg_surface_stride = surf; cfg_line_stride = line;
        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_ch_groups = DIM_W'(g);
        start_req = 1'b1;
        while (done_cnt == 0 && cyc < 6000) begin
            if (cyc == inject) begin
                start_req = 1'b1;
                cfg_base_addr = 32'h1234_0000;
                cfg_height = '0;
            end
            step();
            if (cyc == 2) begin
                check("busy_after_start", busy, 1'b1);
                check("err_cleared", err, 1'b0);
            end
            if (abort_at >= 0 && cyc == abort_at) begin
                check("pre_rst_busy", busy, 1'b1);
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", busy, 1'b0);
                check("rst_awvalid", m_awvalid, 1'b0);
                check("rst_wvalid", m_wvalid, 1'b0);
                s_valid = 1'b0; m_bvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
                start = 1'b0; start_req = 1'b0; s_take = 1'b0; b_take = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        if (done_cnt == 0) begin
            check("done_timeout", 1'b0, 1'b1);
            return;
        end
        if (n_bursts == 0) check("degen_latency", cyc <= 3, 1'b1);
        check("aw_count", aw_cnt, n_bursts);
        check("w_beats", w_beats, nb);
        check("w_bursts", w_bursts, n_bursts);
        check("b_before_done", b_cnt, n_bursts);
        check("aw_left", exp_q.size(), 0);
        check("err_at_done", err, (ei >= 0) && (ei < n_bursts));
        step();
        check("done_single", done_cnt, 1);
        check("idle_after_done", busy, 1'b0);
        check("err_sticky", err, (ei >= 0) && (ei < n_bursts));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy0", busy, 1'b0);
        check("rst_done0", done, 1'b0);
        check("rst_err0", err, 1'b0);
        check("rst_awvalid0", m_awvalid, 1'b0);
        check("rst_wvalid0", m_wvalid, 1'b0);
        check("rst_sready0", s_ready, 1'b0);
        check("rst_bready0", m_bready, 1'b0);
        check("rst_awaddr0", m_awaddr, '0);
        check("rst_awlen", m_awlen, 8'd15);
        check("rst_awburst", m_awburst, 2'b01);
        check("rst_wstrb", m_wstrb, {(AXI_DW/8){1'b1}});
        rst_n = 1'b1;

        run_test(32'h0800_0000, 32'h800, 32'h800, 32, 1, 4, 0, 100, 100, 100, 0, -1, -1, -1);
        run_test(32'h0800_0000, 32'h800, 32'h800, 32, 1, 4, 50, 100, 50, 70, 20, -1, -1, -1);
        run_test(32'h0800_0000, 32'hC00, 32'h400, 16, 3, 2, 0, 80, 80, 90, 3, -1, -1, -1);
        run_test(32'h0800_0000, 32'h800, 32'h800, 32, 1, 4, 0, 100, 100, 100, 2, 2, 10, -1);
        run_test(32'h0800_0000, 32'h800, 32'h800, 32, 1, 4, 0, 100, 100, 100, 0, -1, -1, -1);
        run_test(32'h0800_0000, 32'h800, 32'h800, 32, 0, 4, 0, 100, 100, 100, 0, -1, -1, -1);
        run_test(32'h0800_0000, 32'h800, 32'h800, 32, 1, 4, 0, 100, 100, 100, 0, -1, -1, 30);
        run_test(32'h0800_0000, 32'h800, 32'h800, 32, 1, 4, 0, 100, 100, 100, 0, -1, -1, -1);
        for (int r = 0; r < 3; r++) begin
            run_test(32'h1000_0000 + 32'($urandom_range(0, 255)) * 32'h400,
                     32'($urandom_range(1, 64)) * 32'h400,
                     32'($urandom_range(1, 16)) * 32'h400,
                     BL * $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                     $urandom_range(0, 20), $urandom_range(40, 100), $urandom_range(30, 100),
                     $urandom_range(40, 100), $urandom_range(0, 15),
                     (r == 1) ? 0 : -1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
